// File: rtl/lfsr_prbs_checker_if.sv
// ---------------------------------------------------------------------------
// lfsr_prbs_checker_if
//   Stream-side bundle for the PRBS checker.
//   master : the link / bench side. Drives the serial stream and the counter
//            clear, and observes the lock and error status.
//   slave  : the checker side.
//   Signals:
//     din_valid   din carries a stream bit this cycle
//     din         serial PRBS bit
//     clr_counts  synchronous clear of err_count and bit_count
//     locked      checker is synchronised to the stream
//     err_pulse   one-cycle flag for a mismatched bit while locked
//     err_count   saturating count of mismatches while locked
//     bit_count   saturating count of valid bits checked while locked
//   CNT_W must match the CNT_W of the checker that is connected to it.
// ---------------------------------------------------------------------------
interface lfsr_prbs_checker_if #(
  parameter int CNT_W = 16
);
  logic             din_valid;
  logic             din;
  logic             clr_counts;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] bit_count;

  modport master (
    output din_valid, din, clr_counts,
    input  locked, err_pulse, err_count, bit_count
  );

  modport slave (
    input  din_valid, din, clr_counts,
    output locked, err_pulse, err_count, bit_count
  );
endinterface

// File: rtl/lfsr_prbs_checker.sv
// ---------------------------------------------------------------------------
// lfsr_prbs_checker
//   Receive-side checker for the serial PRBS of the 8-bit Fibonacci LFSR
//   generator (next = {s[0]^s[1]^s[5], s[W-1:1]}, serial bit = s[0]).
//   The checker fills a local history from the stream and then verifies
//   LOCK_CNT consecutive predictions before it declares lock. Once locked,
//   it runs as a flywheel: the history is advanced from its own prediction,
//   so corrupted received bits are counted but never enter the history.
//   LOSS_CNT consecutive mismatches drop lock and restart the fill.
//
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous, active-high reset
//     bus  lfsr_prbs_checker_if.slave
//          (din_valid, din, clr_counts in; locked, err_pulse,
//           err_count, bit_count out, all outputs registered)
// ---------------------------------------------------------------------------
module lfsr_prbs_checker #(
  parameter int WIDTH    = 8,   // LFSR length, taps fixed at 0,1,5 (>= 6)
  parameter int LOCK_CNT = 16,  // consecutive matches needed to lock
  parameter int LOSS_CNT = 4,   // consecutive mismatches that drop lock
  parameter int CNT_W    = 16   // width of err_count and bit_count
) (
  input  logic                      clk,
  input  logic                      rst,
  lfsr_prbs_checker_if.slave        bus
);

  localparam int FW = $clog2(WIDTH + 1);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int SW = $clog2(LOSS_CNT + 1);

  // Terminal values are compared before the increment, so the counters never
  // need to hold the terminal count itself.
  localparam logic [FW-1:0]    FILL_LAST = FW'(WIDTH - 1);
  localparam logic [MW-1:0]    LOCK_LAST = MW'(LOCK_CNT - 1);
  localparam logic [SW-1:0]    LOSS_LAST = SW'(LOSS_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_VERIFY,
    ST_LOCKED
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] h_q;
  logic [FW-1:0]    fill_q;
  logic [MW-1:0]    match_q;
  logic [SW-1:0]    miss_q;
  logic             locked_q;
  logic             err_pulse_q;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [CNT_W-1:0] bit_count_q, bit_count_d;

  logic pred;
  logic mismatch;
  logic bit_inc;
  logic err_inc;

  // -------------------------------------------------------------------------
  // Prediction and saturating counter next-state
  // -------------------------------------------------------------------------
  // NOTE: every variable driven here gets a value before any condition, so
  // no path can leave it holding its old value and infer a latch.
  always_comb begin
    pred     = h_q[0] ^ h_q[1] ^ h_q[5];
    mismatch = bus.din ^ pred;
    bit_inc  = bus.din_valid && (state_q == ST_LOCKED);
    err_inc  = bit_inc && mismatch;

    // Clear first, then add: clear plus increment yields 1.
    err_count_d = bus.clr_counts ? '0 : err_count_q;
    if (err_inc && (err_count_d != CNT_MAX)) begin
      err_count_d = err_count_d + CNT_W'(1);
    end

    bit_count_d = bus.clr_counts ? '0 : bit_count_q;
    if (bit_inc && (bit_count_d != CNT_MAX)) begin
      bit_count_d = bit_count_d + CNT_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Sync FSM, history and registered outputs
  // -------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FILL;
      h_q         <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      miss_q      <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
      bit_count_q <= '0;
    end else begin
      err_pulse_q <= err_inc;
      err_count_q <= err_count_d;
      bit_count_q <= bit_count_d;

      if (bus.din_valid) begin
        unique case (state_q)
          ST_FILL: begin
            h_q <= {bus.din, h_q[WIDTH-1:1]};
            if (fill_q == FILL_LAST) begin
              fill_q  <= '0;
              match_q <= '0;
              state_q <= ST_VERIFY;
            end else begin
              fill_q <= fill_q + FW'(1);
            end
          end

          ST_VERIFY: begin
            h_q <= {bus.din, h_q[WIDTH-1:1]};
            if (h_q == '0) begin
              // All-zero history is the LFSR lock-up state; refill, counting
              // the current bit as the first of the new fill.
              fill_q  <= FW'(1);
              state_q <= ST_FILL;
            end else if (!mismatch) begin
              if (match_q == LOCK_LAST) begin
                miss_q   <= '0;
                locked_q <= 1'b1;
                state_q  <= ST_LOCKED;
              end else begin
                match_q <= match_q + MW'(1);
              end
            end else begin
              fill_q  <= FW'(1);
              state_q <= ST_FILL;
            end
          end

          ST_LOCKED: begin
            if (mismatch && (miss_q == LOSS_LAST)) begin
              // History is left as it stands; the refill overwrites it.
              miss_q   <= '0;
              fill_q   <= '0;
              locked_q <= 1'b0;
              state_q  <= ST_FILL;
            end else begin
              // Flywheel: advance from the prediction, not the received bit.
              h_q    <= {pred, h_q[WIDTH-1:1]};
              miss_q <= mismatch ? miss_q + SW'(1) : '0;
            end
          end

          default: begin
            fill_q   <= '0;
            locked_q <= 1'b0;
            state_q  <= ST_FILL;
          end
        endcase
      end
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_count = err_count_q;
  assign bus.bit_count = bit_count_q;

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// ---------------------------------------------------------------------------
// tb_lfsr_prbs_checker
//   Drives a generator stream (INIT=1) into lfsr_prbs_checker. A behavioural
//   reference of the checker produces the expected outputs for every driven
//   cycle; they are queued and compared one cycle later, #1 after the edge.
//   Directed checks pin down lock latency, error reporting, loss/relock,
//   the all-zero stream, gapped input, reset and clear-with-error.
// ---------------------------------------------------------------------------
module tb_lfsr_prbs_checker;

  localparam int WIDTH    = 8;
  localparam int LOCK_CNT = 16;
  localparam int LOSS_CNT = 4;
  localparam int CNT_W    = 16;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  localparam int M_FILL   = 0;
  localparam int M_VERIFY = 1;
  localparam int M_LOCKED = 2;

  typedef struct {
    logic locked;
    logic pulse;
    int   err;
    int   bits;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  lfsr_prbs_checker_if #(.CNT_W(CNT_W)) tif ();

  lfsr_prbs_checker #(
    .WIDTH    (WIDTH),
    .LOCK_CNT (LOCK_CNT),
    .LOSS_CNT (LOSS_CNT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (tif.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  exp_t sb[$];

  // Reference model state
  int         m_state;
  logic [7:0] m_h;
  int         m_fill, m_match, m_miss, m_err, m_bits;
  logic       m_locked, m_pulse;

  // Generator state
  logic [7:0] g;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic gen_bit();
    logic b;
    b = g[0];
    g = {g[0] ^ g[1] ^ g[5], g[7:1]};
    return b;
  endfunction

  task automatic model(input logic r, input logic v, input logic d,
                       input logic c);
    logic p;
    logic inc_b, inc_e;
    if (r) begin
      m_state = M_FILL; m_h = '0; m_fill = 0; m_match = 0; m_miss = 0;
      m_err = 0; m_bits = 0; m_locked = 0; m_pulse = 0;
      return;
    end
    p     = m_h[0] ^ m_h[1] ^ m_h[5];
    inc_b = 0;
    inc_e = 0;
    if (v) begin
      if (m_state == M_FILL) begin
        m_h = {d, m_h[7:1]};
        m_fill++;
        if (m_fill == WIDTH) begin
          m_state = M_VERIFY;
          m_match = 0;
        end
      end else if (m_state == M_VERIFY) begin
        if (m_h == 0) begin
          m_h = {d, m_h[7:1]}; m_fill = 1; m_state = M_FILL;
        end else if (d == p) begin
          m_h = {d, m_h[7:1]};
          m_match++;
          if (m_match == LOCK_CNT) begin
            m_state = M_LOCKED; m_miss = 0;
          end
        end else begin
          m_h = {d, m_h[7:1]}; m_fill = 1; m_state = M_FILL;
        end
      end else begin
        inc_b = 1;
        if (d != p) begin
          inc_e = 1;
          m_miss++;
          if (m_miss == LOSS_CNT) begin
            m_state = M_FILL; m_fill = 0; m_miss = 0;
          end else begin
            m_h = {p, m_h[7:1]};
          end
        end else begin
          m_miss = 0;
          m_h = {p, m_h[7:1]};
        end
      end
    end
    if (c) begin
      m_err  = 0;
      m_bits = 0;
    end
    if (inc_e && m_err < CNT_MAX) m_err++;
    if (inc_b && m_bits < CNT_MAX) m_bits++;
    m_pulse  = inc_e;
    m_locked = (m_state == M_LOCKED);
  endtask

  // One clock: drive inputs, queue the expectation, compare after the edge.
  task automatic step(input logic r, input logic v, input logic d,
                      input logic c);
    exp_t e;
    rst            = r;
    tif.din_valid  = v;
    tif.din        = d;
    tif.clr_counts = c;
    model(r, v, d, c);
    e.locked = m_locked;
    e.pulse  = m_pulse;
    e.err    = m_err;
    e.bits   = m_bits;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("sb_locked",    32'(tif.locked),    32'(e.locked));
    check("sb_err_pulse", 32'(tif.err_pulse), 32'(e.pulse));
    check("sb_err_count", 32'(tif.err_count), 32'(e.err));
    check("sb_bit_count", 32'(tif.bit_count), 32'(e.bits));
  endtask

  task automatic clean(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, gen_bit(), 1'b0);
  endtask

  initial begin
    logic seen_lock;

    // Reset
    g = 8'h01;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("rst_locked",    32'(tif.locked),    32'd0);
    check("rst_err_pulse", 32'(tif.err_pulse), 32'd0);
    check("rst_err_count", 32'(tif.err_count), 32'd0);
    check("rst_bit_count", 32'(tif.bit_count), 32'd0);

    // 1: clean continuous stream, 1000 bits
    for (int i = 1; i <= 1000; i++) begin
      step(1'b0, 1'b1, gen_bit(), 1'b0);
      if (i == 23) check("t1_not_locked_23", 32'(tif.locked), 32'd0);
      if (i == 24) check("t1_locked_24",     32'(tif.locked), 32'd1);
    end
    check("t1_err_count", 32'(tif.err_count), 32'd0);
    check("t1_bit_count", 32'(tif.bit_count), 32'd976);

    // 2: single inverted bit while locked
    step(1'b0, 1'b1, ~gen_bit(), 1'b0);
    check("t2_pulse_hi",  32'(tif.err_pulse), 32'd1);
    check("t2_err_count", 32'(tif.err_count), 32'd1);
    check("t2_locked",    32'(tif.locked),    32'd1);
    step(1'b0, 1'b1, gen_bit(), 1'b0);
    check("t2_pulse_lo",  32'(tif.err_pulse), 32'd0);
    clean(50);
    check("t2_flywheel_err", 32'(tif.err_count), 32'd1);
    check("t2_flywheel_lock", 32'(tif.locked),   32'd1);

    // 3: four consecutive inverted bits drop lock, then relock
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("t3_clr_err",  32'(tif.err_count), 32'd0);
    check("t3_clr_bits", 32'(tif.bit_count), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, 1'b1, ~gen_bit(), 1'b0);
      if (k == 3) check("t3_still_locked", 32'(tif.locked), 32'd1);
    end
    check("t3_lock_lost", 32'(tif.locked),    32'd0);
    check("t3_err_count", 32'(tif.err_count), 32'd4);
    clean(23);
    check("t3_relock_23", 32'(tif.locked), 32'd0);
    clean(1);
    check("t3_relock_24", 32'(tif.locked), 32'd1);

    // 4: all-zero stream never locks
    step(1'b1, 1'b0, 1'b0, 1'b0);
    seen_lock = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      seen_lock |= tif.locked;
    end
    check("t4_never_locked", 32'(seen_lock),     32'd0);
    check("t4_err_count",    32'(tif.err_count), 32'd0);
    check("t4_bit_count",    32'(tif.bit_count), 32'd0);

    // 5: gapped stream, valid every other cycle; din on gaps is junk
    step(1'b1, 1'b0, 1'b0, 1'b0);
    g = 8'h01;
    for (int c = 0; c < 148; c++) begin
      if (c % 2 == 0) step(1'b0, 1'b1, gen_bit(), 1'b0);
      else            step(1'b0, 1'b0, 1'($urandom_range(1)), 1'b0);
      if (c == 45) check("t5_not_locked", 32'(tif.locked), 32'd0);
      if (c == 46) check("t5_locked",     32'(tif.locked), 32'd1);
    end
    check("t5_bit_count", 32'(tif.bit_count), 32'd50);
    check("t5_err_count", 32'(tif.err_count), 32'd0);

    // 6a: reset while locked, with other inputs active
    step(1'b1, 1'b1, gen_bit(), 1'b1);
    check("t6_rst_locked",    32'(tif.locked),    32'd0);
    check("t6_rst_err_pulse", 32'(tif.err_pulse), 32'd0);
    check("t6_rst_err_count", 32'(tif.err_count), 32'd0);
    check("t6_rst_bit_count", 32'(tif.bit_count), 32'd0);

    // 6b: relock, build up counts, then clear together with an error
    clean(24);
    check("t6_relocked", 32'(tif.locked), 32'd1);
    step(1'b0, 1'b1, ~gen_bit(), 1'b0);
    clean(5);
    check("t6_pre_clr_err", 32'(tif.err_count), 32'd1);
    step(1'b0, 1'b1, ~gen_bit(), 1'b1);
    check("t6_clr_err_count", 32'(tif.err_count), 32'd1);
    check("t6_clr_bit_count", 32'(tif.bit_count), 32'd1);
    check("t6_clr_pulse",     32'(tif.err_pulse), 32'd1);
    clean(10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
